// File: rtl/alu_seq_if.sv
// Operand/opcode request channel and registered result/flag channel of alu_seq.
// Latency: none; this is wiring only.
// Backpressure: the request side is held off by in_ready. The result side has none, so the consumer samples on out_valid.
// Ports: master drives in_valid/op/a/b; slave returns in_ready, out_valid, f, flag_z/n/c/v.
interface alu_seq_if #(
  parameter int WIDTH = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] f;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;

  modport master (
    output in_valid, op, a, b,
    input  in_ready, out_valid, f, flag_z, flag_n, flag_c, flag_v
  );

  modport slave (
    input  in_valid, op, a, b,
    output in_ready, out_valid, f, flag_z, flag_n, flag_c, flag_v
  );
endinterface

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with Z/N/C/V flags and an iterative shift-add multiply.
// Latency: 1 clock for every op except MUL. MUL takes WIDTH clocks after it is accepted.
// Backpressure: in_ready is low while a multiply runs, and in_valid is ignored then. The result side is a bare out_valid pulse.
// Ports: clk, rst (async, active-high), bus (alu_seq_if.slave): in_valid/in_ready/op/a/b in, out_valid/f/flag_z/n/c/v out.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SHL  = 4'd2;
  localparam logic [3:0] OP_SHR  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_ROL  = 4'd9;
  localparam logic [3:0] OP_ROR  = 4'd10;
  localparam logic [3:0] OP_PASS = 4'd11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   a_shift;
  logic [WIDTH-1:0]     b_shift;
  logic [CNT_W-1:0]     cnt;

  // Single-cycle datapath.
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       diff;
  logic [WIDTH-1:0]     rot_amt;
  logic [2*WIDTH-1:0]   rol_full;
  logic [2*WIDTH-1:0]   ror_full;
  logic [WIDTH-1:0]     res;
  logic                 res_c;
  logic                 res_v;
  logic [2*WIDTH-1:0]   acc_next;
  logic                 accept;

  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    sum      = {1'b0, bus.a} + {1'b0, bus.b};
    diff     = {1'b0, bus.a} - {1'b0, bus.b};
    rot_amt  = WIDTH'(bus.b % WIDTH);
    // Rotating through a doubled copy of a avoids a variable-width barrel mux.
    rol_full = {bus.a, bus.a} << rot_amt;
    ror_full = {bus.a, bus.a} >> rot_amt;
    res      = '0;
    res_c    = 1'b0;
    res_v    = 1'b0;
    case (bus.op)
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        res   = diff[WIDTH-1:0];
        // The extra top bit of the zero-extended difference is the unsigned borrow.
        res_c = diff[WIDTH];
        res_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SHL:  res = (bus.b >= WIDTH) ? '0 : (bus.a << bus.b);
      OP_SHR:  res = (bus.b >= WIDTH) ? '0 : (bus.a >> bus.b);
      OP_AND:  res = bus.a & bus.b;
      OP_OR:   res = bus.a | bus.b;
      OP_XOR:  res = bus.a ^ bus.b;
      OP_NOT:  res = ~bus.a;
      OP_ROL:  res = rol_full[2*WIDTH-1:WIDTH];
      OP_ROR:  res = ror_full[WIDTH-1:0];
      OP_PASS: res = bus.a;
      default: res = '0;  // reserved opcodes (and MUL, which never uses this path)
    endcase
  end

  assign acc_next = acc + (b_shift[0] ? a_shift : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.f         <= '0;
      bus.flag_z    <= 1'b0;
      bus.flag_n    <= 1'b0;
      bus.flag_c    <= 1'b0;
      bus.flag_v    <= 1'b0;
      acc           <= '0;
      a_shift       <= '0;
      b_shift       <= '0;
      cnt           <= '0;
    end else begin
      bus.out_valid <= 1'b0;
      case (state)
        IDLE: begin
          bus.in_ready <= 1'b1;
          if (accept) begin
            if (bus.op == OP_MUL) begin
              state        <= MUL;
              bus.in_ready <= 1'b0;
              acc          <= '0;
              a_shift      <= {{WIDTH{1'b0}}, bus.a};
              b_shift      <= bus.b;
              cnt          <= '0;
            end else begin
              bus.out_valid <= 1'b1;
              bus.f         <= res;
              bus.flag_z    <= (res == '0);
              bus.flag_n    <= res[WIDTH-1];
              bus.flag_c    <= res_c;
              bus.flag_v    <= res_v;
            end
          end
        end
        MUL: begin
          acc     <= acc_next;
          a_shift <= a_shift << 1;
          b_shift <= b_shift >> 1;
          cnt     <= cnt + 1'b1;
          // The last partial product is folded in on this same edge, so the
          // flags are taken from acc_next rather than from acc.
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b1;
            bus.f         <= acc_next[WIDTH-1:0];
            bus.flag_z    <= (acc_next[WIDTH-1:0] == '0);
            bus.flag_n    <= acc_next[WIDTH-1];
            bus.flag_c    <= |acc_next[2*WIDTH-1:WIDTH];
            bus.flag_v    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
